conv1_sequencer: RTL and testbench

Address and control sequencer for the conv1 layer: 5×5 kernel, 3→32 channels, 32×32 "same" convolution. It walks every output pixel, drives read addresses into the input, weight and bias memories, and issues bias-load and accumulate strobes to the MAC datapath. It writes each finished sum to the 32768-entry conv1 output memory. It runs after the host controller has filled the input, weight and bias memories, and is started by that controller.

---
 rtl/conv1_sequencer_pkg.sv | 44 ++++
 rtl/conv1_sequencer_window_addr.sv | 65 ++++++
 rtl/conv1_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_conv1_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// conv1_sequencer_pkg : conv1 layer constants, derived sizes, FSM encoding
// rev 1.0
// ============================================================================
package conv1_sequencer_pkg;

  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int IN_CH  = 3;
  localparam int OUT_CH = 32;
  localparam int K      = 5;
  localparam int PAD    = 2;

  localparam int IN_LEN  = IN_CH * IMG_W * IMG_H;
  localparam int W_LEN   = OUT_CH * IN_CH * K * K;
  localparam int OUT_LEN = OUT_CH * IMG_W * IMG_H;
  localparam int TAPS    = IN_CH * K * K;

  localparam int IN_AW   = $clog2(IN_LEN);
  localparam int W_AW    = $clog2(W_LEN);
  localparam int OUT_AW  = $clog2(OUT_LEN);
  localparam int OC_W    = $clog2(OUT_CH);
  localparam int COORD_W = $clog2(IMG_W);
  localparam int IC_W    = $clog2(IN_CH);
  localparam int KW      = $clog2(K);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Input-plane coordinate of a tap; may fall outside the image (padding).
  function automatic logic signed [6:0] tap_coord(input logic [COORD_W-1:0] p,
                                                  input logic [KW-1:0]      k);
    return $signed(7'(p)) + $signed(7'(k)) - $signed(7'(PAD));
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv1_sequencer_window_addr.sv
`default_nettype none
// ============================================================================
// conv_window_addr : (ic, ky, kx) tap counter, padding test, in/w addresses
// rev 1.0
// ============================================================================
module conv_window_addr
  import conv1_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               advance,
  input  logic [OC_W-1:0]    oc,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] x,
  output logic               pad,
  output logic               last,
  output logic [IN_AW-1:0]   in_addr,
  output logic [W_AW-1:0]    w_addr
);

  logic [IC_W-1:0]   r_ic;
  logic [KW-1:0]     r_ky;
  logic [KW-1:0]     r_kx;
  logic signed [6:0] w_iy;
  logic signed [6:0] w_ix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ic <= '0;
      r_ky <= '0;
      r_kx <= '0;
    end else if (clear) begin
      r_ic <= '0;
      r_ky <= '0;
      r_kx <= '0;
    end else if (advance) begin
      if (r_kx == KW'(K-1)) begin
        r_kx <= '0;
        if (r_ky == KW'(K-1)) begin
          r_ky <= '0;
          r_ic <= (r_ic == IC_W'(IN_CH-1)) ? '0 : r_ic + 1'b1;
        end else begin
          r_ky <= r_ky + 1'b1;
        end
      end else begin
        r_kx <= r_kx + 1'b1;
      end
    end
  end

  assign w_iy = tap_coord(y, r_ky);
  assign w_ix = tap_coord(x, r_kx);

  assign pad  = (w_iy < 7'sd0) || (w_iy > $signed(7'(IMG_H-1))) ||
                (w_ix < 7'sd0) || (w_ix > $signed(7'(IMG_W-1)));
  assign last = (r_ic == IC_W'(IN_CH-1)) && (r_ky == KW'(K-1)) && (r_kx == KW'(K-1));

  // Power-of-two image dims let the plane/row/column offsets be concatenated.
  assign in_addr = pad ? '0 : {r_ic, w_iy[COORD_W-1:0], w_ix[COORD_W-1:0]};
  assign w_addr  = W_AW'(oc) * W_AW'(TAPS) + W_AW'(r_ic) * W_AW'(K*K) +
                   W_AW'(r_ky) * W_AW'(K) + W_AW'(r_kx);

endmodule
`default_nettype wire

// File: rtl/conv1_sequencer.sv
`default_nettype none
// ============================================================================
// conv1_sequencer : walks conv1 output pixels, drives memory reads and MAC strobes
// rev 1.0
// ============================================================================
module conv1_sequencer
  import conv1_sequencer_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              in_rd,
  output logic [IN_AW-1:0]  in_addr,
  output logic              w_rd,
  output logic [W_AW-1:0]   w_addr,
  output logic              b_rd,
  output logic [OC_W-1:0]   b_addr,
  output logic              mac_load,
  output logic              mac_en,
  output logic              mac_zero,
  output logic              mac_last,
  output logic              out_wr,
  output logic [OUT_AW-1:0] out_addr,
  input  logic              out_ready
);

  state_t               r_state;
  logic [OC_W-1:0]      r_oc;
  logic [COORD_W-1:0]   r_y;
  logic [COORD_W-1:0]   r_x;
  logic [7:0]           r_drain;
  logic                 r_iss_zero;
  logic                 r_iss_last;
  logic [MEM_LAT-1:0]   r_dl_load;
  logic [MEM_LAT-1:0]   r_dl_en;
  logic [MEM_LAT-1:0]   r_dl_zero;
  logic [MEM_LAT-1:0]   r_dl_last;

  logic                 w_issue;
  logic                 w_win_clr;
  logic                 w_pad;
  logic                 w_last;
  logic [IN_AW-1:0]     w_in_addr;
  logic [W_AW-1:0]      w_w_addr;
  logic [OC_W-1:0]      w_oc_nx;
  logic [COORD_W-1:0]   w_y_nx;
  logic [COORD_W-1:0]   w_x_nx;
  logic                 w_last_pix;

  // A tap goes out on the BIAS->ACCUM edge and on every ACCUM edge until the last one is on the bus.
  assign w_issue   = (r_state == S_BIAS) || ((r_state == S_ACCUM) && !r_iss_last);
  assign w_win_clr = (r_state == S_IDLE);

  conv_window_addr u_win (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_win_clr),
    .advance (w_issue),
    .oc      (r_oc),
    .y       (r_y),
    .x       (r_x),
    .pad     (w_pad),
    .last    (w_last),
    .in_addr (w_in_addr),
    .w_addr  (w_w_addr)
  );

  always_comb begin
    w_x_nx  = r_x + 1'b1;
    w_y_nx  = r_y;
    w_oc_nx = r_oc;
    if (r_x == COORD_W'(IMG_W-1)) begin
      w_x_nx = '0;
      if (r_y == COORD_W'(IMG_H-1)) begin
        w_y_nx  = '0;
        w_oc_nx = r_oc + 1'b1;
      end else begin
        w_y_nx = r_y + 1'b1;
      end
    end
  end

  assign w_last_pix = (r_oc == OC_W'(OUT_CH-1)) && (r_y == COORD_W'(IMG_H-1)) &&
                      (r_x == COORD_W'(IMG_W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_oc       <= '0;
      r_y        <= '0;
      r_x        <= '0;
      r_drain    <= '0;
      r_iss_zero <= 1'b0;
      r_iss_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_rd      <= 1'b0;
      in_addr    <= '0;
      w_rd       <= 1'b0;
      w_addr     <= '0;
      b_rd       <= 1'b0;
      b_addr     <= '0;
      out_wr     <= 1'b0;
      out_addr   <= '0;
    end else begin
      done       <= 1'b0;
      b_rd       <= 1'b0;
      b_addr     <= '0;
      in_rd      <= 1'b0;
      in_addr    <= '0;
      w_rd       <= 1'b0;
      w_addr     <= '0;
      r_iss_zero <= 1'b0;
      r_iss_last <= 1'b0;
      if (w_issue) begin
        w_rd       <= 1'b1;
        w_addr     <= w_w_addr;
        in_rd      <= !w_pad;
        in_addr    <= w_in_addr;
        r_iss_zero <= w_pad;
        r_iss_last <= w_last;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_BIAS;
            busy    <= 1'b1;
            b_rd    <= 1'b1;
            b_addr  <= r_oc;
          end
        end
        S_BIAS:  r_state <= S_ACCUM;
        S_ACCUM: begin
          if (r_iss_last) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end
        end
        S_DRAIN: begin
          if (r_drain == 8'(MEM_LAT-1)) begin
            r_state  <= S_WRITE;
            out_wr   <= 1'b1;
            out_addr <= {r_oc, r_y, r_x};
          end else begin
            r_drain <= r_drain + 8'd1;
          end
        end
        S_WRITE: begin
          if (out_ready) begin
            out_wr   <= 1'b0;
            out_addr <= '0;
            r_oc     <= w_oc_nx;
            r_y      <= w_y_nx;
            r_x      <= w_x_nx;
            if (w_last_pix) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state <= S_BIAS;
              b_rd    <= 1'b1;
              b_addr  <= w_oc_nx;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory-latency alignment for the MAC strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dl_load <= '0;
      r_dl_en   <= '0;
      r_dl_zero <= '0;
      r_dl_last <= '0;
    end else begin
      r_dl_load[0] <= b_rd;
      r_dl_en[0]   <= w_rd;
      r_dl_zero[0] <= r_iss_zero;
      r_dl_last[0] <= r_iss_last;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_dl_load[i] <= r_dl_load[i-1];
        r_dl_en[i]   <= r_dl_en[i-1];
        r_dl_zero[i] <= r_dl_zero[i-1];
        r_dl_last[i] <= r_dl_last[i-1];
      end
    end
  end

  assign mac_load = r_dl_load[MEM_LAT-1];
  assign mac_en   = r_dl_en[MEM_LAT-1];
  assign mac_zero = r_dl_zero[MEM_LAT-1];
  assign mac_last = r_dl_last[MEM_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_conv1_sequencer.sv
`default_nettype none
// ============================================================================
// tb_conv1_sequencer : trace model, per-pixel tables and corner sequences
// rev 1.0
// ============================================================================
module tb_conv1_sequencer;

  localparam int ML     = 1;
  localparam int L      = 1 + 75 + ML + 1;
  localparam int NPIX_A = 200;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        in_rd;
    logic [11:0] in_addr;
    logic        w_rd;
    logic [11:0] w_addr;
    logic        b_rd;
    logic [4:0]  b_addr;
    logic        mac_load;
    logic        mac_en;
    logic        mac_zero;
    logic        mac_last;
    logic        out_wr;
    logic [14:0] out_addr;
  } outs_t;

  typedef struct {
    int pix;
    int pads;
    int fu_in;
    int fu_w;
    int last_in;
    int last_w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, in_rd, w_rd, b_rd, mac_load, mac_en, mac_zero, mac_last, out_wr;
  logic [11:0] in_addr, w_addr;
  logic [4:0]  b_addr;
  logic [14:0] out_addr;
  outs_t       act;

  always #5 clk = ~clk;

  conv1_sequencer #(.MEM_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_rd(in_rd), .in_addr(in_addr), .w_rd(w_rd), .w_addr(w_addr),
    .b_rd(b_rd), .b_addr(b_addr), .mac_load(mac_load), .mac_en(mac_en),
    .mac_zero(mac_zero), .mac_last(mac_last), .out_wr(out_wr),
    .out_addr(out_addr), .out_ready(out_ready)
  );

  assign act = {busy, done, in_rd, in_addr, w_rd, w_addr, b_rd, b_addr,
                mac_load, mac_en, mac_zero, mac_last, out_wr, out_addr};

  int n_chk = 0;
  int n_err = 0;
  bit m_run = 1'b0;
  int m_p = 0;
  int m_k = 0;
  bit model_on = 1'b1;

  bit st_on = 1'b0;
  int sp = 0;
  int s_pads[NPIX_A], s_en[NPIX_A], s_lastpos[NPIX_A], s_out[NPIX_A];
  int s_fu_in[NPIX_A], s_fu_w[NPIX_A], s_last_in[NPIX_A], s_last_w[NPIX_A];
  bit s_seen[NPIX_A];
  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit tap_pad(input int y, input int x, input int j);
    int iy, ix;
    iy = y + (j / 5) % 5 - 2;
    ix = x + j % 5 - 2;
    return (iy < 0) || (iy > 31) || (ix < 0) || (ix > 31);
  endfunction

  function automatic int tap_in(input int y, input int x, input int j);
    return (j / 25) * 1024 + (y + (j / 5) % 5 - 2) * 32 + (x + j % 5 - 2);
  endfunction

  // Expected outputs on cycle k of pixel p (k=0 is the bias read).
  function automatic outs_t exp_out(input int p, input int k);
    outs_t o;
    int oc, y, x, j;
    o  = '0;
    oc = p / 1024;
    y  = (p / 32) % 32;
    x  = p % 32;
    o.busy = 1'b1;
    if (k == 0) begin
      o.b_rd   = 1'b1;
      o.b_addr = 5'(oc);
    end
    if (k == ML) o.mac_load = 1'b1;
    if (k >= 1 && k <= 75) begin
      j = k - 1;
      o.w_rd   = 1'b1;
      o.w_addr = 12'(oc * 75 + j);
      if (!tap_pad(y, x, j)) begin
        o.in_rd   = 1'b1;
        o.in_addr = 12'(tap_in(y, x, j));
      end
    end
    if (k >= 1 + ML && k <= 75 + ML) begin
      j = k - 1 - ML;
      o.mac_en   = 1'b1;
      o.mac_zero = tap_pad(y, x, j);
      o.mac_last = (j == 74);
    end
    if (k == L - 1) begin
      o.out_wr   = 1'b1;
      o.out_addr = 15'(p);
    end
    return o;
  endfunction

  // Called at a falling edge: check this cycle, drive inputs for it, step the model.
  task automatic cycle(input bit rdy, input bit st);
    outs_t e;
    e = m_run ? exp_out(m_p, m_k) : '0;
    if (model_on) begin
      chk($sformatf("trace run=%0d p=%0d k=%0d", m_run, m_p, m_k), 64'(act), 64'(e));
      if (n_err > 40) model_on = 1'b0;
    end
    if (st_on && sp < NPIX_A) begin
      if (w_rd) begin
        s_last_in[sp] = int'(in_addr);
        s_last_w[sp]  = int'(w_addr);
      end
      if (in_rd && !s_seen[sp]) begin
        s_seen[sp]  = 1'b1;
        s_fu_in[sp] = int'(in_addr);
        s_fu_w[sp]  = int'(w_addr);
      end
      if (mac_en) begin
        s_en[sp]++;
        if (mac_zero) s_pads[sp]++;
      end
      if (mac_last) s_lastpos[sp] = s_en[sp];
      if (out_wr) s_out[sp] = int'(out_addr);
      if (out_wr && rdy) sp++;
    end
    out_ready = rdy;
    start     = st;
    if (!rst_n) m_run = 1'b0;
    else if (!m_run) begin
      if (st) begin
        m_run = 1'b1;
        m_p   = 0;
        m_k   = 0;
      end
    end else if (m_k < L - 1) m_k++;
    else if (rdy) begin
      m_p++;
      m_k = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    int tgt, guard, bp_addr;
    vt[0] = '{0,   48, 0,  12, 2114, 74};
    vt[1] = '{2,   30, 0,  10, 2116, 74};
    vt[2] = '{31,  48, 29, 10, 0,    74};
    vt[3] = '{33,  27, 0,  6,  2147, 74};
    vt[4] = '{100, 0,  34, 0,  2214, 74};
    vt[5] = '{165, 0,  99, 0,  2279, 74};

    @(negedge clk);
    repeat (3) cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (20) cycle(1'b0, 1'b0);

    // Uninterrupted run over the first rows, collecting per-pixel statistics.
    st_on = 1'b1;
    cycle(1'b1, 1'b1);
    while (m_p < NPIX_A) cycle(1'b1, 1'b0);
    st_on = 1'b0;

    // Ten cycles of backpressure in WRITE.
    while (m_k != L - 1) cycle(1'b1, 1'b0);
    bp_addr = m_p;
    for (int i = 0; i < 10; i++) begin
      chk("bp out_wr", 64'(out_wr), 64'(1));
      chk("bp out_addr", 64'(out_addr), 64'(bp_addr));
      chk("bp strobes", 64'({in_rd, w_rd, b_rd, mac_load, mac_en, mac_zero, mac_last}), 64'(0));
      cycle(1'b0, 1'b0);
    end
    cycle(1'b1, 1'b0);
    chk("bp next b_rd", 64'(b_rd), 64'(1));
    chk("bp next b_addr", 64'(b_addr), 64'(m_p / 1024));

    // Random backpressure with stray start pulses while busy.
    tgt   = m_p + 150;
    guard = 0;
    while (m_p < tgt && guard < 40000) begin
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
      guard++;
    end
    if (guard >= 40000) begin
      n_chk++;
      n_err++;
      $display("FAIL random phase timeout: got %0d pixels expected %0d", m_p, tgt);
    end

    // Asynchronous reset on the 40th tap of a pixel.
    while (m_k != 40) cycle(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", 64'(act), 64'(0));
    @(negedge clk);
    m_run = 1'b0;
    repeat (2) cycle(1'b1, 1'b0);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    chk("restart b_rd", 64'(b_rd), 64'(1));
    chk("restart b_addr", 64'(b_addr), 64'(0));
    while (m_k != L - 1) cycle(1'b1, 1'b0);
    chk("restart out_wr", 64'(out_wr), 64'(1));
    chk("restart out_addr", 64'(out_addr), 64'(0));
    cycle(1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      int p;
      p = vt[i].pix;
      chk($sformatf("pix%0d mac_en count", p), 64'(s_en[p]), 64'(75));
      chk($sformatf("pix%0d mac_last position", p), 64'(s_lastpos[p]), 64'(75));
      chk($sformatf("pix%0d padded taps", p), 64'(s_pads[p]), 64'(vt[i].pads));
      chk($sformatf("pix%0d first unpadded in_addr", p), 64'(s_fu_in[p]), 64'(vt[i].fu_in));
      chk($sformatf("pix%0d first unpadded w_addr", p), 64'(s_fu_w[p]), 64'(vt[i].fu_w));
      chk($sformatf("pix%0d last in_addr", p), 64'(s_last_in[p]), 64'(vt[i].last_in));
      chk($sformatf("pix%0d last w_addr", p), 64'(s_last_w[p]), 64'(vt[i].last_w));
      chk($sformatf("pix%0d out_addr", p), 64'(s_out[p]), 64'(p));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
